// File: rtl/rat_io_hub.sv
// rat_io_hub: port-mapped I/O hub for the RAT MCU port bus.
// Provides N_OUT 8-bit output registers with readback, N_IN input ports and an
// interrupt aggregator (sync, rising-edge capture, PENDING/MASK, W1C ack).
// Optional macro RAT_IO_DEBOUNCE_EN inserts a per-source debounce filter
// between the synchroniser and the edge detector.
module rat_io_hub #(
  parameter int         N_OUT     = 4,
  parameter int         N_IN      = 4,
  parameter int         N_IRQ     = 4,
  parameter logic [7:0] OUT_BASE  = 8'h40,
  parameter logic [7:0] IN_BASE   = 8'h20,
  parameter logic [7:0] IRQ_BASE  = 8'hF0,
  parameter int         DB_CYCLES = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  input  logic               IO_STRB,
  output logic [7:0]         IN_PORT,
  input  logic [8*N_IN-1:0]  IN_DATA,
  output logic [8*N_OUT-1:0] OUT_DATA,
  input  logic [N_IRQ-1:0]   IRQ_SRC,
  output logic               INT_R
);

  // Parameter sanity, caught at elaboration
  if (N_OUT < 1 || N_OUT > 8) begin : g_bad_nout
    $error("rat_io_hub: N_OUT must be 1..8");
  end
  if (N_IN < 1 || N_IN > 8) begin : g_bad_nin
    $error("rat_io_hub: N_IN must be 1..8");
  end
  if (N_IRQ < 1 || N_IRQ > 8) begin : g_bad_nirq
    $error("rat_io_hub: N_IRQ must be 1..8");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("rat_io_hub: DB_CYCLES must be >= 1");
  end

  logic [7:0]       r_out [N_OUT];
  logic [N_OUT-1:0] w_out_hit;
  logic             w_pend_hit;
  logic             w_mask_hit;
  logic [7:0]       w_rd;

  logic [N_IRQ-1:0] r_s1;
  logic [N_IRQ-1:0] r_s2;
  logic [N_IRQ-1:0] r_s3;
  logic [N_IRQ-1:0] r_pend;
  logic [N_IRQ-1:0] r_mask;
  logic             r_int;
  logic [N_IRQ-1:0] w_lvl;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_clr;

  // Address decode for output registers and the interrupt register pair
  always_comb begin
    w_out_hit = '0;
    for (int k = 0; k < N_OUT; k++) begin
      w_out_hit[k] = (PORT_ID == OUT_BASE + 8'(k));
    end
    w_pend_hit = (PORT_ID == IRQ_BASE);
    w_mask_hit = (PORT_ID == IRQ_BASE + 8'd1);
  end

  // Output registers: strobed write, cleared by reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < N_OUT; k++) begin
        r_out[k] <= 8'h00;
      end
    end else if (IO_STRB) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (w_out_hit[k]) begin
          r_out[k] <= OUT_PORT;
        end
      end
    end
  end

  // Flatten output registers onto the OUT_DATA bus
  always_comb begin
    OUT_DATA = '0;
    for (int k = 0; k < N_OUT; k++) begin
      OUT_DATA[8*k +: 8] = r_out[k];
    end
  end

  // Read mux: later assignments win, giving output > IRQ > input priority
  always_comb begin
    w_rd = 8'h00;
    for (int k = 0; k < N_IN; k++) begin
      if (PORT_ID == IN_BASE + 8'(k)) begin
        w_rd = IN_DATA[8*k +: 8];
      end
    end
    if (w_pend_hit) begin
      w_rd = 8'(r_pend);
    end else if (w_mask_hit) begin
      w_rd = 8'(r_mask);
    end else begin
      w_rd = w_rd;
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (w_out_hit[k]) begin
        w_rd = r_out[k];
      end
    end
  end

  assign IN_PORT = w_rd;

`ifdef RAT_IO_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);

  logic [DB_W-1:0]  r_db_cnt [N_IRQ];
  logic [N_IRQ-1:0] r_db_lvl;

  // Debounce: follow s2 only after it has disagreed for DB_CYCLES straight cycles
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_db_lvl <= '0;
      for (int k = 0; k < N_IRQ; k++) begin
        r_db_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_IRQ; k++) begin
        if (r_s2[k] != r_db_lvl[k]) begin
          if (r_db_cnt[k] == DB_W'(DB_CYCLES - 1)) begin
            r_db_lvl[k] <= r_s2[k];
            r_db_cnt[k] <= '0;
          end else begin
            r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
          end
        end else begin
          r_db_cnt[k] <= '0;
        end
      end
    end
  end

  assign w_lvl = r_db_lvl;
`else
  assign w_lvl = r_s2;
`endif

  // Edge detect and write-1-to-clear mask; a same-cycle rise overrides the clear
  always_comb begin
    w_rise = w_lvl & ~r_s3;
    w_clr  = (IO_STRB && w_pend_hit) ? OUT_PORT[N_IRQ-1:0] : '0;
  end

  // Interrupt state: synchroniser, PENDING, MASK and the registered request
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_pend <= '0;
      r_mask <= '0;
      r_int  <= 1'b0;
    end else begin
      r_s1   <= IRQ_SRC;
      r_s2   <= r_s1;
      r_s3   <= w_lvl;
      r_pend <= (r_pend & ~w_clr) | w_rise;
      if (IO_STRB && w_mask_hit) begin
        r_mask <= OUT_PORT[N_IRQ-1:0];
      end
      r_int  <= |(r_pend & r_mask);
    end
  end

  assign INT_R = r_int;

endmodule

// File: doc/rat_io_hub.md
# rat_io_hub

Parametrised port-mapped I/O hub between the RAT MCU port bus (PORT_ID / OUT_PORT / IO_STRB / IN_PORT) and board peripherals. It replaces the fixed LED/seven-segment registers and the single switch input with N output registers, N input ports and output readback. It also adds an interrupt aggregator that feeds the MCU interrupt line: per-source synchroniser, rising-edge capture, pending/mask registers and write-1-to-clear acknowledge.

## Interface
- N_OUT, 4: number of 8-bit output registers, 1..8
- N_IN, 4: number of 8-bit input ports, 1..8
- N_IRQ, 4: number of interrupt sources, 1..8
- OUT_BASE, 8'h40: port ID of output register 0; register k sits at OUT_BASE+k
- IN_BASE, 8'h20: port ID of input port 0; input port k sits at IN_BASE+k
- IRQ_BASE, 8'hF0: interrupt PENDING register at IRQ_BASE, MASK register at IRQ_BASE+1
- DB_CYCLES, 16: debounce stability count; used only with RAT_IO_DEBOUNCE_EN
- CLK  in  1  single system clock; all state on posedge CLK
- RESET  in  1  asynchronous, active-high reset
- PORT_ID  in  8  MCU port address
- OUT_PORT  in  8  MCU write data
- IO_STRB  in  1  MCU write strobe, one cycle per OUT instruction
- IN_PORT  out  8  read data to MCU, combinational from PORT_ID
- IN_DATA  in  8*N_IN  input port k = IN_DATA[8k+7:8k]
- OUT_DATA  out  8*N_OUT  output register k = OUT_DATA[8k+7:8k]
- IRQ_SRC  in  N_IRQ  asynchronous interrupt request levels
- INT_R  out  1  registered interrupt request to MCU

## Operation
- Write: at posedge CLK with IO_STRB=1, a PORT_ID match loads the target. Output register k <= OUT_PORT. MASK <= OUT_PORT[N_IRQ-1:0]. A PENDING write clears every bit k where OUT_PORT[k]=1 (write-1-to-clear). Unmapped IDs are ignored.
- Read mux, combinational, priority output > IRQ > input when address ranges overlap:
  - OUT_BASE+k returns output register k (readback).
  - IRQ_BASE returns PENDING, zero-extended.
  - IRQ_BASE+1 returns MASK, zero-extended.
  - IN_BASE+k returns IN_DATA byte k.
  - Any other ID returns 8'h00.
- Interrupt path per source k:
  - s1 <= IRQ_SRC[k]; s2 <= s1; s3 <= s2.
  - rise = s2 & ~s3.
  - rise sets PENDING[k]. The set is independent of MASK, so masked events stay latched.
- INT_R <= |(PENDING & MASK), registered.
- A rise on source k and a PENDING clear of bit k in the same cycle: set wins, bit stays 1.
- A MASK write takes effect on INT_R one cycle after the write edge.
- Register bits at positions >= N_IRQ read 0 and are not writable.
- Reset (asynchronous, any time, including mid-write): all output registers 8'h00, PENDING 0, MASK 0 (all sources disabled), s1/s2/s3 0, INT_R 0. A source already high when reset releases therefore registers one rise.

## Timing
- Writes: visible on OUT_DATA and on readback immediately after the strobed edge.
- IN_PORT: zero-latency combinational from PORT_ID, IN_DATA and register state.
- Interrupt latency, no debounce: IRQ_SRC high set up before edge E0 gives s2=1 after E1, PENDING set at E2, INT_R=1 after E3.
- INT_R deassertion: one edge after the PENDING clear write or the MASK write that removes the last active bit.
- Pulses on IRQ_SRC shorter than one CLK period may be missed.
- Pulses of one period or longer are captured exactly once per rising edge. Further rises while the bit is pending are absorbed; there is no counting.

## Configuration
- RAT_IO_DEBOUNCE_EN defined:
  - Each source gets a debounce counter between s2 and the edge detector.
  - The debounced level changes only after s2 differs from it for DB_CYCLES consecutive cycles. Any mismatch gap restarts the count.
  - rise is taken from the debounced level, adding DB_CYCLES cycles of latency.
  - Counters reset to 0; the debounced level resets to 0.
- Undefined: no counters, rise comes straight from s2/s3, DB_CYCLES is ignored.

## Test plan
- Reset, then write 8'hA5 to 8'h40 and 8'h3C to 8'h43 -> OUT_DATA byte0=A5 and byte3=3C, other bytes 00; reads of 8'h40 and 8'h43 return A5 and 3C.
- IN_DATA byte2=8'h5A; read 8'h22 -> IN_PORT=5A; read 8'h77 -> 00; an IO_STRB write to 8'h77 changes no state.
- MASK=8'h01; IRQ_SRC[0] 0->1 -> PENDING=01 two edges later, INT_R=1 one edge after that; write 8'h01 to 8'hF0 -> PENDING=00, INT_R=0 next edge.
- MASK=0; pulse IRQ_SRC[2] -> PENDING=04, INT_R stays 0; then write MASK=8'h04 -> INT_R=1 one cycle later.
- Rise on source 1 in the same cycle as a write of 8'h02 to 8'hF0 -> PENDING[1] stays 1.
- Assert RESET asynchronously mid-pattern -> all outputs 00 and INT_R=0 without a clock edge. With RAT_IO_DEBOUNCE_EN and DB_CYCLES=16, a 10-cycle glitch produces no PENDING bit, and a 20-cycle pulse sets it.
